tile_collector: RTL and testbench
=================================

# tile_collector

Consumer at the output end of a `tile`. Watches the tile's per-cycle `metric`/`msg` stream and discards samples until the hashing pipeline has filled. Keeps the best candidate (highest metric = most matching digest bits) and raises a flag on a full 160-bit match. Streams the winning message out as 32-bit words over a valid/ready port, for the host-side readout logic.

## Interface

- `MSG_W`, 512 (512 × BLOCKS), message width; must be a multiple of 32
- `METRIC_W`, 9, metric width; matches tile `metric_o`
- `WARMUP`, 245, cycles of tile output to discard after `run_i` rises; the tile pipeline plus metric latency
- `FULL`, 160, metric value that means a full digest match

Ports:

- `clk_i`  in  1  clock; everything is on its rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `run_i`  in  1  tile is running: RNGs are seeded and the stream is advancing
- `clear_i`  in  1  discard the stored best candidate
- `metric_i`  in  METRIC_W  tile `metric_o`
- `msg_i`  in  MSG_W  tile `msg_o`, aligned with `metric_i`
- `best_val_o`  out  1  a best candidate is held
- `best_metric_o`  out  METRIC_W  metric of the held candidate
- `hit_o`  out  1  sticky: held metric ≥ `FULL`
- `rd_req_i`  in  1  pulse to start a readout
- `rd_rdy_i`  in  1  consumer ready
- `rd_val_o`  out  1  `rd_data_o` valid
- `rd_data_o`  out  32  readout word
- `rd_last_o`  out  1  current word is the final word

## Operation

- **Warmup counter `wcnt`**
  - Cleared while `run_i` = 0.
  - Increments each cycle `run_i` = 1 and saturates at `WARMUP`.
  - A sample is valid when `run_i` = 1 and `wcnt` = `WARMUP`.
  - Any drop of `run_i` restarts warmup.
- **Capture**
  - On a valid sample, capture `metric_i`/`msg_i` if `best_val_o` = 0 or `metric_i` > `best_metric_o`.
  - Comparison is unsigned.
  - On a tie, keep the older candidate.
  - Capture sets `best_val_o`.
- **Freeze during readout:** no capture while the FSM is not IDLE. Samples arriving during that time are dropped.
- **Clear**
  - `clear_i` zeroes `best_val_o`, `best_metric_o` and `hit_o`.
  - Clear has priority over a same-cycle capture; that sample is discarded.
  - Clear is ignored while the FSM is not IDLE.
- **Hit:** `hit_o` is set on capture when the captured metric ≥ `FULL`. It stays set until clear or reset.
- **Readout FSM**
  - States:
    - **IDLE:** `rd_val_o` = 0. `rd_req_i` with `best_val_o` = 1 → SEND, word index `k` = 0. `rd_req_i` with `best_val_o` = 0 is ignored.
    - **SEND:** `rd_val_o` = 1. On `rd_val_o & rd_rdy_i`, `k` increments. A transfer with `rd_last_o` = 1 → IDLE.
  - Total words N = `MSG_W`/32 + 1.
  - Word 0 = {zeros, `best_metric_o`}.
  - Word k ≥ 1 = `best_msg[32(k−1)+31 : 32(k−1)]`, low word first.
  - `rd_last_o` = (k = N−1) while in SEND.
  - `rd_req_i` while in SEND is ignored.
  - Data must hold stable while `rd_val_o` = 1 and `rd_rdy_i` = 0.
- **Widths**
  - `k` is `$clog2(N)` bits.
  - `wcnt` is `$clog2(WARMUP+1)` bits.

## Timing

- **Reset values:** `wcnt` = 0, FSM = IDLE, and all outputs 0 (`best_val_o`, `best_metric_o`, `hit_o`, `rd_val_o`, `rd_data_o`, `rd_last_o`).
- **Warmup:** with `run_i` high from cycle 0, the first valid sample is at cycle `WARMUP`.
- **Capture latency:** 1 cycle. A valid sample at cycle t is visible on `best_*`/`hit_o` at t+1.
- **Readout start:** `rd_req_i` at cycle t gives `rd_val_o` = 1 with word 0 at t+1.
- **Readout throughput:** with `rd_rdy_i` held high, one word per cycle; the burst finishes at t+N and the FSM is IDLE at t+N+1.
- `rd_data_o` and `rd_last_o` are combinational from `k` and the held registers. There is no combinational path from `rd_rdy_i` to `rd_val_o`.
- **Capture resumes** the cycle after the last transfer; the first capture updates `best_*` on the following cycle.
- **Reset mid-readout:** FSM returns to IDLE, `rd_val_o` = 0 next cycle, and the stored candidate is lost.
- **`run_i` dropped mid-readout:** readout continues unaffected, and warmup restarts when `run_i` rises again.

## Test plan

- **Warmup and first capture:** `WARMUP` = 4, `run_i` = 1, metric 10, 20, 30, 40, 50, … in cycles 0–4. Required: samples 0–3 are ignored, `best_metric_o` = 50 at cycle 5, and `best_val_o` rises at cycle 5.
- **Max and tie tracking:** metrics 80, 120, 120, 90, with distinct messages. Required: `best_metric_o` = 120 and the held message is the first 120 sample. Drop `run_i` for 1 cycle: the next `WARMUP` samples are ignored even if their metric is 150.
- **Hit and clear:** capture 160. Required: `hit_o` = 1 the next cycle. Then `clear_i` coincident with a metric-170 sample: `best_val_o` = 0, `hit_o` = 0, and the sample is not captured.
- **Readout with backpressure:** `MSG_W` = 512, best metric 0x5A, message words 0x0…0xF. Pulse `rd_req_i`, `rd_rdy_i` = 1010…
  - Required: 17 words, 0x5A then 0x0…0xF, data stable on stalled cycles, `rd_last_o` only on 0xF.
  - A metric-200 sample during the burst does not change `best_metric_o`.
- **Empty request and reset mid-burst:** `rd_req_i` with `best_val_o` = 0 leaves `rd_val_o` = 0 for the following 3 cycles. `reset_i` at word 5 gives `rd_val_o` = 0 and `best_val_o` = 0 the cycle after.

Source files
------------

// File: rtl/tile_collector.sv
// tile_collector: output-side consumer of a hashing tile.
// Drops the stream until the tile pipeline has filled, keeps the highest-metric
// candidate (older one wins ties), flags a full digest match, and streams the
// held candidate out as 32-bit words on a valid/ready port.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   run_i                 tile stream is advancing
//   clear_i               drop the held candidate (only honoured in IDLE)
//   metric_i, msg_i       tile sample stream
//   best_val_o            a candidate is held
//   best_metric_o         metric of the held candidate
//   hit_o                 sticky full-match flag
//   rd_req_i              pulse to start a readout
//   rd_rdy_i              readout consumer ready
//   rd_val_o, rd_data_o,  readout word stream: word 0 = metric,
//   rd_last_o             then message words, low word first
module tile_collector #(
  parameter int unsigned MSG_W    = 512,
  parameter int unsigned METRIC_W = 9,
  parameter int unsigned WARMUP   = 245,
  parameter int unsigned FULL     = 160
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                run_i,
  input  logic                clear_i,
  input  logic [METRIC_W-1:0] metric_i,
  input  logic [MSG_W-1:0]    msg_i,
  output logic                best_val_o,
  output logic [METRIC_W-1:0] best_metric_o,
  output logic                hit_o,
  input  logic                rd_req_i,
  input  logic                rd_rdy_i,
  output logic                rd_val_o,
  output logic [31:0]         rd_data_o,
  output logic                rd_last_o
);

  localparam int unsigned N  = MSG_W / 32 + 1;
  localparam int unsigned KW = $clog2(N);
  localparam int unsigned WW = $clog2(WARMUP + 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [WW-1:0]         wcnt_q, wcnt_d;
  logic                  best_val_q, best_val_d;
  logic [METRIC_W-1:0]   best_metric_q, best_metric_d;
  logic [MSG_W-1:0]      best_msg_q, best_msg_d;
  logic                  hit_q, hit_d;
  logic                  sample_vld;
  logic [31:0]           msg_word;

  assign sample_vld = run_i && (wcnt_q == WW'(WARMUP));

  // Warmup counter and best-candidate tracking; frozen outside IDLE.
  always_comb begin
    wcnt_d        = wcnt_q;
    best_val_d    = best_val_q;
    best_metric_d = best_metric_q;
    best_msg_d    = best_msg_q;
    hit_d         = hit_q;
    if (!run_i) begin
      wcnt_d = '0;
    end else if (wcnt_q != WW'(WARMUP)) begin
      wcnt_d = wcnt_q + WW'(1);
    end
    if (state_q == IDLE) begin
      if (clear_i) begin
        best_val_d    = 1'b0;
        best_metric_d = '0;
        hit_d         = 1'b0;
      end else if (sample_vld && (!best_val_q || (metric_i > best_metric_q))) begin
        best_val_d    = 1'b1;
        best_metric_d = metric_i;
        best_msg_d    = msg_i;
        hit_d         = hit_q | (metric_i >= METRIC_W'(FULL));
      end
    end
  end

  // Readout FSM next state.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (rd_req_i && best_val_q) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (rd_rdy_i) begin
          if (k_q == KW'(N - 1)) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      k_q           <= '0;
      wcnt_q        <= '0;
      best_val_q    <= 1'b0;
      best_metric_q <= '0;
      best_msg_q    <= '0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wcnt_q        <= wcnt_d;
      best_val_q    <= best_val_d;
      best_metric_q <= best_metric_d;
      best_msg_q    <= best_msg_d;
      hit_q         <= hit_d;
    end
  end

  // Message word k-1 for k >= 1.
  always_comb begin
    msg_word = '0;
    for (int j = 0; j < int'(N) - 1; j++) begin
      if (k_q == KW'(j + 1)) begin
        msg_word = best_msg_q[32*j +: 32];
      end
    end
  end

  assign rd_val_o      = (state_q == SEND);
  assign rd_data_o     = (state_q != SEND) ? 32'd0 :
                         (k_q == '0)       ? 32'(best_metric_q) : msg_word;
  assign rd_last_o     = (state_q == SEND) && (k_q == KW'(N - 1));
  assign best_val_o    = best_val_q;
  assign best_metric_o = best_metric_q;
  assign hit_o         = hit_q;

endmodule

// File: tb/tb_tile_collector.sv
// Bench for tile_collector with a short warmup; readout words are checked by a
// scoreboard monitor, candidate state by directed checks.
module tb_tile_collector;

  localparam int unsigned MSG_W    = 512;
  localparam int unsigned METRIC_W = 9;
  localparam int unsigned WARMUP   = 4;
  localparam int unsigned FULL     = 160;
  localparam int unsigned NW       = MSG_W / 32 + 1;

  logic                clk = 1'b0;
  logic                reset_i, run_i, clear_i, rd_req_i, rd_rdy_i;
  logic [METRIC_W-1:0] metric_i;
  logic [MSG_W-1:0]    msg_i;
  logic                best_val_o, hit_o, rd_val_o, rd_last_o;
  logic [METRIC_W-1:0] best_metric_o;
  logic [31:0]         rd_data_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [32:0] exp_q[$];

  tile_collector #(
    .MSG_W(MSG_W), .METRIC_W(METRIC_W), .WARMUP(WARMUP), .FULL(FULL)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .run_i(run_i), .clear_i(clear_i),
    .metric_i(metric_i), .msg_i(msg_i),
    .best_val_o(best_val_o), .best_metric_o(best_metric_o), .hit_o(hit_o),
    .rd_req_i(rd_req_i), .rd_rdy_i(rd_rdy_i),
    .rd_val_o(rd_val_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on every transfer, checks hold during stalls.
  logic        stall_prev = 1'b0;
  logic [32:0] held_word  = '0;
  always @(negedge clk) begin
    if (stall_prev && rd_val_o)
      check("stall_hold", {31'd0, rd_last_o, rd_data_o}, {31'd0, held_word});
    if (rd_val_o && rd_rdy_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {31'd0, rd_last_o, rd_data_o}, 64'hDEAD);
      end else begin
        check("rd_word", {31'd0, rd_last_o, rd_data_o}, {31'd0, exp_q.pop_front()});
      end
    end
    stall_prev = rd_val_o && !rd_rdy_i;
    held_word  = {rd_last_o, rd_data_o};
  end

  task automatic set_pattern_msg();
    msg_i = '0;
    for (int j = 0; j < int'(NW) - 1; j++) msg_i[32*j +: 32] = 32'(j);
  endtask

  // Run a burst to completion; alt toggles ready 1,0,1,0...; inject drives a
  // high-metric sample mid-burst that must be dropped.
  task automatic drain(input bit alt, input bit inject);
    int c;
    c = 0;
    while (rd_val_o && c < 80) begin
      rd_rdy_i = alt ? (c % 2 == 0) : 1'b1;
      if (inject && c == 3) metric_i = 9'd200;
      if (inject && c == 4) metric_i = 9'h5A;
      step();
      if (inject && c == 5) check("frozen_metric", 64'(best_metric_o), 64'h5A);
      c++;
    end
    check("burst_done", 64'(rd_val_o), 64'd0);
    rd_rdy_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; run_i = 1'b0; clear_i = 1'b0; rd_req_i = 1'b0; rd_rdy_i = 1'b0;
    metric_i = '0; msg_i = '0;
    step(); step();
    check("rst_best_val", 64'(best_val_o), 64'd0);
    check("rst_best_metric", 64'(best_metric_o), 64'd0);
    check("rst_hit", 64'(hit_o), 64'd0);
    check("rst_rd_val", 64'(rd_val_o), 64'd0);
    check("rst_rd_data", 64'(rd_data_o), 64'd0);
    check("rst_rd_last", 64'(rd_last_o), 64'd0);
    reset_i = 1'b0;

    // Warmup: first WARMUP samples ignored, sample 4 (metric 50) captured.
    run_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      metric_i = METRIC_W'(10 * (i + 1));
      step();
      if (i < 4) check("warmup_ignored", 64'(best_val_o), 64'd0);
    end
    check("first_val", 64'(best_val_o), 64'd1);
    check("first_metric", 64'(best_metric_o), 64'd50);

    // Max and tie tracking.
    begin
      logic [METRIC_W-1:0] mv[4];
      logic [METRIC_W-1:0] ev[4];
      mv = '{9'd80, 9'd120, 9'd120, 9'd90};
      ev = '{9'd80, 9'd120, 9'd120, 9'd120};
      for (int i = 0; i < 4; i++) begin
        metric_i = mv[i];
        msg_i = '0;
        msg_i[31:0] = 32'hA0 + 32'(i);
        step();
        check("max_track", 64'(best_metric_o), 64'(ev[i]));
      end
    end
    metric_i = '0;
    // Readout proves the first 120 message (0xA1) was kept.
    exp_q.push_back({1'b0, 32'd120});
    exp_q.push_back({1'b0, 32'hA1});
    for (int j = 2; j < int'(NW); j++) exp_q.push_back({(j == int'(NW) - 1), 32'd0});
    rd_req_i = 1'b1; rd_rdy_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    check("rd_start", 64'(rd_val_o), 64'd1);
    drain(1'b0, 1'b0);

    // Drop run for one cycle: next WARMUP samples ignored even at 150.
    run_i = 1'b0;
    step();
    run_i = 1'b1;
    metric_i = 9'd150;
    for (int i = 0; i < int'(WARMUP); i++) begin
      step();
      check("rewarm_ignored", 64'(best_metric_o), 64'd120);
    end
    check("no_hit_yet", 64'(hit_o), 64'd0);

    // Hit and clear.
    metric_i = 9'd160;
    step();
    check("hit_metric", 64'(best_metric_o), 64'd160);
    check("hit_set", 64'(hit_o), 64'd1);
    metric_i = 9'd170; clear_i = 1'b1;
    step();
    clear_i = 1'b0; run_i = 1'b0; metric_i = '0;
    check("clear_val", 64'(best_val_o), 64'd0);
    check("clear_hit", 64'(hit_o), 64'd0);
    check("clear_metric", 64'(best_metric_o), 64'd0);

    // Readout with backpressure.
    run_i = 1'b1; metric_i = 9'h5A; set_pattern_msg();
    for (int i = 0; i < 5; i++) step();
    check("bp_captured", 64'(best_metric_o), 64'h5A);
    exp_q.push_back({1'b0, 32'h5A});
    for (int j = 1; j < int'(NW); j++) exp_q.push_back({(j == int'(NW) - 1), 32'(j - 1)});
    rd_req_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    drain(1'b1, 1'b1);
    check("bp_metric_after", 64'(best_metric_o), 64'h5A);
    run_i = 1'b0;

    // Empty request is ignored.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    rd_req_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("empty_req", 64'(rd_val_o), 64'd0);
      step();
    end

    // Reset mid-burst at word 5.
    run_i = 1'b1; metric_i = 9'h33; set_pattern_msg();
    for (int i = 0; i < 5; i++) step();
    run_i = 1'b0;
    check("rst_burst_cap", 64'(best_metric_o), 64'h33);
    exp_q.push_back({1'b0, 32'h33});
    for (int j = 1; j < 5; j++) exp_q.push_back({1'b0, 32'(j - 1)});
    rd_req_i = 1'b1; rd_rdy_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rd_rdy_i = 1'b0; reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("midrst_rd_val", 64'(rd_val_o), 64'd0);
    check("midrst_best_val", 64'(best_val_o), 64'd0);
    step();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
